hazard_spike_encoder: RTL

- Downstream of `hazard_encoder`; consumes its 32-cell occupancy map (`vec1`/`vec2`).
- Converts each captured frame into address-event (AER) spikes for the neuromorphic core: every occupied cell emits one spike per timestep, over `NUM_STEPS` timesteps.
- Output is a valid/ready event stream with step and frame boundary pulses.

---
 rtl/hazard_spike_encoder.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/hazard_spike_encoder.sv
// ---------------------------------------------------------------------------
// hazard_spike_encoder
//
// Purpose:
//   Turns one 32-cell occupancy frame into a stream of address-event (AER)
//   spikes. Every occupied cell emits one spike per timestep, and there are
//   NUM_STEPS timesteps per frame. Each timestep scans the cells in ascending
//   order, one cell per cycle, and then spends one cycle on a step-end marker.
//   With aer_ready held high, one timestep therefore takes 33 cycles.
//
// Optional feature (macro HAZARD_SPIKE_RATE_EN):
//   Adds an 8-bit spike_rate input and a 16-bit Fibonacci LFSR
//   (taps 16,14,13,11, seed 16'hACE1). An occupied cell fires only when
//   lfsr[7:0] < spike_rate. The LFSR advances once per scanned cell and holds
//   while an event is stalled. Keep spike_rate constant during a frame so that
//   a stalled event stays stable.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   frame_valid  vec1/vec2 carry a new occupancy frame
//   frame_ready  idle, a frame is accepted this cycle
//   vec1, vec2   cells 0-15 and 16-31
//   aer_valid    spike event presented
//   aer_ready    consumer accepts the event
//   aer_addr     cell index of the event
//   aer_step     timestep of the event
//   step_done    one-cycle pulse at the end of each timestep
//   frame_done   one-cycle pulse at the end of the final timestep
//   busy         frame in progress
//   spike_rate   (HAZARD_SPIKE_RATE_EN only) firing threshold
// ---------------------------------------------------------------------------
module hazard_spike_encoder #(
    parameter int NUM_STEPS = 8,
    parameter int STEP_W    = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_valid,
    output logic              frame_ready,
    input  logic [15:0]       vec1,
    input  logic [15:0]       vec2,
    output logic              aer_valid,
    input  logic              aer_ready,
    output logic [4:0]        aer_addr,
    output logic [STEP_W-1:0] aer_step,
    output logic              step_done,
    output logic              frame_done,
`ifdef HAZARD_SPIKE_RATE_EN
    input  logic [7:0]        spike_rate,
`endif
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        STEP_END
    } state_t;

    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NUM_STEPS - 1);

    state_t            state;
    logic [31:0]       occ;
    logic [4:0]        ptr;
    logic [STEP_W-1:0] step;
    logic              fire;
    logic              advance;

`ifdef HAZARD_SPIKE_RATE_EN
    logic [15:0] lfsr;
    logic        lfsr_fb;
`endif

    // Decide whether the cell under the pointer emits an event this cycle.
    // A cell that does not fire is skipped in a single cycle; a firing cell
    // waits for the consumer before the scan moves on.
    always_comb begin
`ifdef HAZARD_SPIKE_RATE_EN
        lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
        fire    = occ[ptr] && (lfsr[7:0] < spike_rate);
`else
        fire    = occ[ptr];
`endif
        advance = (state == SCAN) && (!fire || aer_ready);
    end

    // Main controller: capture the frame, walk the 32 cells for every
    // timestep, and insert one step-end cycle after each pass. Only this
    // block changes occ, so the frame stays frozen until it is finished.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            occ   <= '0;
            ptr   <= '0;
            step  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (frame_valid) begin
                        occ   <= {vec2, vec1};
                        ptr   <= '0;
                        step  <= '0;
                        state <= SCAN;
                    end
                end
                SCAN: begin
                    if (advance) begin
                        if (ptr == 5'd31) begin
                            state <= STEP_END;
                        end else begin
                            ptr <= ptr + 5'd1;
                        end
                    end
                end
                STEP_END: begin
                    ptr <= '0;
                    if (step == LAST_STEP) begin
                        state <= IDLE;
                    end else begin
                        step  <= STEP_W'(step + 1'b1);
                        state <= SCAN;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef HAZARD_SPIKE_RATE_EN
    // The random source steps once for every cell that finishes evaluation,
    // whether it was occupied or not. It holds during a stall so that the
    // firing decision for the stalled cell does not change.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr <= 16'hACE1;
        end else if (advance) begin
            lfsr <= {lfsr[14:0], lfsr_fb};
        end
    end
`endif

    // All outputs are decoded from registered state only, so none of them
    // depends combinationally on aer_ready or frame_valid.
    assign frame_ready = (state == IDLE);
    assign busy        = (state != IDLE);
    assign aer_valid   = (state == SCAN) && fire;
    assign aer_addr    = ptr;
    assign aer_step    = step;
    assign step_done   = (state == STEP_END);
    assign frame_done  = (state == STEP_END) && (step == LAST_STEP);

endmodule
